// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared types and constants for the sequential ALU.
//   op_e    - 3-bit opcode encoding (ADD..MUL)
//   state_e - control FSM states (IDLE/BUSY/DONE)
//   OP_W    - opcode width
package seq_alu_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_PASS = 3'd5,
        OP_NOT  = 3'd6,
        OP_MUL  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: valid/ready request and response bundle of the sequential ALU.
//   Request : in_valid, in_ready, op, a, b, ci
//   Response: out_valid, out_ready, result, result_hi, co, zero, neg, ovf, illegal
//   master  - issue/writeback side (drives requests, consumes results)
//   slave   - the ALU itself
interface seq_alu_if #(
    parameter int WIDTH = 8
);
    import seq_alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             co;
    logic             zero;
    logic             neg;
    logic             ovf;
    logic             illegal;

    modport master (
        output in_valid, op, a, b, ci, out_ready,
        input  in_ready, out_valid, result, result_hi, co, zero, neg, ovf, illegal
    );

    modport slave (
        input  in_valid, op, a, b, ci, out_ready,
        output in_ready, out_valid, result, result_hi, co, zero, neg, ovf, illegal
    );

endinterface

// File: rtl/seq_alu_addsub.sv
// seq_alu_addsub: combinational WIDTH-bit adder/subtractor.
//   a, b, ci - operands and carry-in
//   sub      - invert b before adding (ci=1 then yields a true a-b)
//   sum      - low WIDTH bits of a + (b ^ sub) + ci
//   co       - carry out of the MSB
//   ovf      - two's-complement overflow
module seq_alu_addsub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    logic [WIDTH-1:0] bEff;

    assign bEff      = b ^ {WIDTH{sub}};
    assign {co, sum} = {1'b0, a} + {1'b0, bEff} + {{WIDTH{1'b0}}, ci};
    // Overflow: both addends share a sign that the sum does not.
    assign ovf       = (a[WIDTH-1] == bEff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked WIDTH-bit ALU with registered result and status flags.
//   clk, rst - clock and asynchronous active-high reset
//   bus      - seq_alu_if slave port (request in, result out)
// Single-cycle ops complete into DONE on the cycle after acceptance; the
// result is held in DONE until out_ready. With SEQ_ALU_MUL_EN defined, MUL
// runs a WIDTH-step shift-add multiply in BUSY through the shared adder;
// without it, MUL completes immediately flagged illegal with a zero result.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    seq_alu_if.slave bus
);

    state_e           state;
    op_e              opIn;

    logic [WIDTH-1:0] resultQ;
    logic [WIDTH-1:0] resultHiQ;
    logic             outValidQ;
    logic             coQ, zeroQ, negQ, ovfQ, illegalQ;

    // Shared adder
    logic [WIDTH-1:0] addA, addB, addSum;
    logic             addCi, addSub, addCo, addOvf;

    // Single-cycle ALU result
    logic [WIDTH-1:0] aluRes;
    logic             aluCo, aluOvf;

    assign opIn = op_e'(bus.op);

    seq_alu_addsub #(.WIDTH(WIDTH)) uAddSub (
        .a   (addA),
        .b   (addB),
        .ci  (addCi),
        .sub (addSub),
        .sum (addSum),
        .co  (addCo),
        .ovf (addOvf)
    );

`ifdef SEQ_ALU_MUL_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] accHi;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] stepHi, stepLo;

    // In BUSY the adder accumulates the multiplicand into the high half;
    // otherwise it serves ADD/SUB straight from the request.
    always_comb begin
        if (state == S_BUSY) begin
            addA   = accHi;
            addB   = mplier[0] ? mcand : '0;
            addCi  = 1'b0;
            addSub = 1'b0;
        end else begin
            addA   = bus.a;
            addB   = bus.b;
            addCi  = bus.ci;
            addSub = (opIn == OP_SUB);
        end
    end

    // {carry, sum, multiplier} shifted right by one: the multiplier register
    // doubles as the low product half, filling from the top as bits retire.
    assign stepHi = {addCo, addSum[WIDTH-1:1]};
    assign stepLo = {addSum[0], mplier[WIDTH-1:1]};
`else
    always_comb begin
        addA   = bus.a;
        addB   = bus.b;
        addCi  = bus.ci;
        addSub = (opIn == OP_SUB);
    end
`endif

    always_comb begin
        aluRes = '0;
        aluCo  = 1'b0;
        aluOvf = 1'b0;
        case (opIn)
            OP_ADD, OP_SUB: begin
                aluRes = addSum;
                aluCo  = addCo;
                aluOvf = addOvf;
            end
            OP_AND:  aluRes = bus.a & bus.b;
            OP_OR:   aluRes = bus.a | bus.b;
            OP_XOR:  aluRes = bus.a ^ bus.b;
            OP_PASS: aluRes = bus.a;
            OP_NOT:  aluRes = ~bus.a;
            default: aluRes = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            outValidQ <= 1'b0;
            resultQ   <= '0;
            resultHiQ <= '0;
            coQ       <= 1'b0;
            zeroQ     <= 1'b0;
            negQ      <= 1'b0;
            ovfQ      <= 1'b0;
            illegalQ  <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            mcand     <= '0;
            mplier    <= '0;
            accHi     <= '0;
            cnt       <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        if (opIn == OP_MUL) begin
`ifdef SEQ_ALU_MUL_EN
                            mcand  <= bus.a;
                            mplier <= bus.b;
                            accHi  <= '0;
                            cnt    <= CNT_W'(WIDTH);
                            state  <= S_BUSY;
`else
                            resultQ   <= '0;
                            resultHiQ <= '0;
                            coQ       <= 1'b0;
                            zeroQ     <= 1'b1;
                            negQ      <= 1'b0;
                            ovfQ      <= 1'b0;
                            illegalQ  <= 1'b1;
                            outValidQ <= 1'b1;
                            state     <= S_DONE;
`endif
                        end else begin
                            resultQ   <= aluRes;
                            resultHiQ <= '0;
                            coQ       <= aluCo;
                            zeroQ     <= (aluRes == '0);
                            negQ      <= aluRes[WIDTH-1];
                            ovfQ      <= aluOvf;
                            illegalQ  <= 1'b0;
                            outValidQ <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
`ifdef SEQ_ALU_MUL_EN
                S_BUSY: begin
                    accHi  <= stepHi;
                    mplier <= stepLo;
                    cnt    <= cnt - CNT_W'(1);
                    // Last step: the shifted value is the final product.
                    if (cnt == CNT_W'(1)) begin
                        resultQ   <= stepLo;
                        resultHiQ <= stepHi;
                        coQ       <= 1'b0;
                        zeroQ     <= ({stepHi, stepLo} == '0);
                        negQ      <= stepHi[WIDTH-1];
                        ovfQ      <= (stepHi != '0);
                        illegalQ  <= 1'b0;
                        outValidQ <= 1'b1;
                        state     <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    if (bus.out_ready) begin
                        outValidQ <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = outValidQ;
    assign bus.result    = resultQ;
    assign bus.result_hi = resultHiQ;
    assign bus.co        = coQ;
    assign bus.zero      = zeroQ;
    assign bus.neg       = negQ;
    assign bus.ovf       = ovfQ;
    assign bus.illegal   = illegalQ;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu at WIDTH=8.
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge. Flags are compared packed as {co,zero,neg,ovf,illegal}.
// Multiplier scenarios are built when SEQ_ALU_MUL_EN is defined; otherwise
// the compiled-out MUL behaviour is exercised.
module tb_seq_alu;
    import seq_alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    seq_alu_if #(.WIDTH(8)) bus ();

    seq_alu #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] flags();
        return {bus.co, bus.zero, bus.neg, bus.ovf, bus.illegal};
    endfunction

    // Present a request on the falling edge and return 1 unit after the
    // rising edge that accepts it.
    task automatic issue(input string tag, input logic [2:0] o, input logic [7:0] x,
                         input logic [7:0] y, input logic c);
        @(negedge clk);
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op = o;
        bus.a  = x;
        bus.b  = y;
        bus.ci = c;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic chkRes(input string tag, input logic [7:0] res, input logic [7:0] hi,
                          input logic [4:0] fl);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, ".in_ready_busy"}, 32'(bus.in_ready), 32'd0);
        chk({tag, ".result"}, 32'(bus.result), 32'(res));
        chk({tag, ".result_hi"}, 32'(bus.result_hi), 32'(hi));
        chk({tag, ".flags"}, 32'(flags()), 32'(fl));
    endtask

    task automatic ack(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, ".ack_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".ack_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.ci        = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        #2;
        chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.result", 32'(bus.result), 32'd0);
        chk("rst.result_hi", 32'(bus.result_hi), 32'd0);
        chk("rst.flags", 32'(flags()), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ADD wrap to zero: carry out, zero, no signed overflow
        issue("add_ff_01", OP_ADD, 8'hFF, 8'h01, 1'b0);
        chkRes("add_ff_01", 8'h00, 8'h00, 5'b11000);
        ack("add_ff_01");

        // SUB 0x80-0x01: 0x80+0xFE+1 = 0x17F, signed overflow
        issue("sub_80_01", OP_SUB, 8'h80, 8'h01, 1'b1);
        chkRes("sub_80_01", 8'h7F, 8'h00, 5'b10010);
        ack("sub_80_01");

        // ADD with carry-in crossing into negative
        issue("add_7f_ci", OP_ADD, 8'h7F, 8'h00, 1'b1);
        chkRes("add_7f_ci", 8'h80, 8'h00, 5'b00110);
        ack("add_7f_ci");

        // Logic ops; ci must not affect them
        issue("and", OP_AND, 8'hC3, 8'h5A, 1'b1);
        chkRes("and", 8'h42, 8'h00, 5'b00000);
        ack("and");
        issue("or", OP_OR, 8'hC3, 8'h5A, 1'b0);
        chkRes("or", 8'hDB, 8'h00, 5'b00100);
        ack("or");
        issue("pass", OP_PASS, 8'h3C, 8'hFF, 1'b0);
        chkRes("pass", 8'h3C, 8'h00, 5'b00000);
        ack("pass");
        issue("not", OP_NOT, 8'h3C, 8'h00, 1'b0);
        chkRes("not", 8'hC3, 8'h00, 5'b00100);
        ack("not");
        issue("and_zero", OP_AND, 8'hF0, 8'h0F, 1'b0);
        chkRes("and_zero", 8'h00, 8'h00, 5'b01000);
        ack("and_zero");

        // Backpressure: XOR result held 5 cycles
        issue("bp_xor", OP_XOR, 8'hA5, 8'h0F, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chkRes($sformatf("bp_hold%0d", i), 8'hAA, 8'h00, 5'b00100);
            @(posedge clk);
            #1;
        end
        // A request offered on the releasing cycle must wait for IDLE
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op = OP_ADD;
        bus.a  = 8'h03;
        bus.b  = 8'h04;
        bus.ci = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("bp_release.out_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_release.in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chkRes("bp_next_add", 8'h07, 8'h00, 5'b00000);

        // Asynchronous reset while holding a result in DONE
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_done.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_done.result", 32'(bus.result), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_done.in_ready", 32'(bus.in_ready), 32'd1);

`ifdef SEQ_ALU_MUL_EN
        // MUL 0xFF*0xFF = 0xFE01: 8 busy cycles, result in the 9th
        issue("mul_ff_ff", OP_MUL, 8'hFF, 8'hFF, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("mul_busy%0d.in_ready", i), 32'(bus.in_ready), 32'd0);
            chk($sformatf("mul_busy%0d.out_valid", i), 32'(bus.out_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        chkRes("mul_ff_ff", 8'h01, 8'hFE, 5'b00110);
        ack("mul_ff_ff");

        // 0x0F*0x03 = 0x002D: high word zero, no overflow
        issue("mul_0f_03", OP_MUL, 8'h0F, 8'h03, 1'b0);
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        chkRes("mul_0f_03", 8'h2D, 8'h00, 5'b00000);
        ack("mul_0f_03");

        // Reset during the 4th BUSY cycle of a MUL
        issue("mul_abort", OP_MUL, 8'h12, 8'h34, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("mul_abort.busy", 32'(bus.in_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("mul_abort.out_valid", 32'(bus.out_valid), 32'd0);
        chk("mul_abort.result", 32'(bus.result), 32'd0);
        chk("mul_abort.result_hi", 32'(bus.result_hi), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mul_abort.in_ready", 32'(bus.in_ready), 32'd1);
        issue("post_abort_add", OP_ADD, 8'h03, 8'h04, 1'b0);
        chkRes("post_abort_add", 8'h07, 8'h00, 5'b00000);
        ack("post_abort_add");
`else
        // Multiplier compiled out: MUL completes in one cycle, illegal
        issue("mul_off", OP_MUL, 8'h02, 8'h03, 1'b0);
        chkRes("mul_off", 8'h00, 8'h00, 5'b01001);
        ack("mul_off");
        issue("post_mul_add", OP_ADD, 8'h03, 8'h04, 1'b0);
        chkRes("post_mul_add", 8'h07, 8'h00, 5'b00000);
        ack("post_mul_add");
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Bound the run in case the sequence stalls.
    initial begin
        #20000;
        $display("FAIL timeout: observed run still active expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked successor to the team's 4-bit combinational 181-style ALU. It adds a WIDTH-bit datapath, registered results with status flags, and an optional iterative unsigned multiplier. The block sits between an operand-issue stage and a writeback stage, both valid/ready. Results are held until the consumer accepts them.

## Interface
- WIDTH, 8: operand and result width; legal range 4–32.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous and active-high; clears all state immediately.
- in_valid  in  1  operands and opcode valid.
- in_ready  out  1  block can accept; high only in IDLE.
- op  in  3  opcode; encodings listed under Operation.
- a, b  in  WIDTH  operands.
- ci  in  1  carry-in, used by ADD and SUB only.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  low result word.
- result_hi  out  WIDTH  high product word for MUL; 0 for all other ops.
- co, zero, neg, ovf, illegal  out  1 each  status flags registered with the result.

## Operation
- Opcodes:
  - 0 ADD: a+b+ci.
  - 1 SUB: a+~b+ci; ci=1 gives a true difference, 181 convention.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 PASS: result=a.
  - 6 NOT: result=~a.
  - 7 MUL: unsigned a*b, 2*WIDTH-bit product.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_valid&in_ready with a non-MUL opcode: compute, register result and flags, go to DONE.
  - MUL: latch a and b, clear accumulator, load counter with WIDTH, go to BUSY.
- BUSY: one shift-add step per cycle using the LSB of the multiplier. The counter decrements each step; when it reaches 0, register the product and go to DONE. Inputs are ignored in BUSY.
- DONE: out_valid=1. When out_ready=1, go to IDLE. Outputs stay stable while out_ready=0.
- Flags:
  - co: adder carry-out for ADD/SUB; 0 for other ops.
  - ovf: signed overflow for ADD/SUB; for MUL, result_hi≠0; 0 for other ops.
  - zero: set when {result_hi,result}==0.
  - neg: MSB of result; for MUL, MSB of result_hi.
  - illegal: 0 unless the multiplier is compiled out (see Configuration).
- All arithmetic is modulo 2^WIDTH, except the MUL product, which is 2*WIDTH bits.

## Timing
- Reset values:
  - State IDLE; in_ready=1, out_valid=0.
  - result=0, result_hi=0; all flags 0.
  - Multiplier registers 0.
- Non-MUL latency: out_valid rises the cycle after acceptance.
- MUL latency: out_valid rises WIDTH+1 cycles after acceptance.
- Throughput: one op per 2 cycles at best. There is no accept in DONE, even when out_ready=1 on the same cycle.
- in_valid while in_ready=0 is not accepted; the upstream must hold its request.
- Reset asserted in BUSY or DONE aborts the operation. Outputs return to their reset values asynchronously, and no partial result is emitted.

## Configuration
- SEQ_ALU_MUL_EN defined: MUL behaves as described above.
- SEQ_ALU_MUL_EN undefined:
  - BUSY state, counter and accumulator are removed.
  - MUL completes like a single-cycle op: result=0, result_hi=0, illegal=1, zero=1, other flags 0.

## Structure
- Package seq_alu_pkg holds:
  - the opcode enum `op_e`;
  - the state enum `state_e`;
  - the constant OP_W=3.
- Sub-module seq_alu_addsub: combinational WIDTH-bit adder.
  - Inputs: a, b, ci, sub.
  - Outputs: sum, co, ovf.
  - It is reused by ADD, SUB and the multiplier accumulate step.

## Test plan
All scenarios use WIDTH=8.
- ADD a=0xFF, b=0x01, ci=0 -> result=0x00, co=1, zero=1, ovf=0; out_valid one cycle after accept.
- SUB a=0x80, b=0x01, ci=1 -> result=0x7F, co=1, ovf=1, neg=0.
- MUL a=0xFF, b=0xFF -> result_hi=0xFE, result=0x01, ovf=1; out_valid 9 cycles after accept, in_ready=0 throughout.
- Backpressure: hold out_ready=0 for 5 cycles after an XOR of 0xA5 and 0x0F -> result=0xAA, neg=1, stable all 5 cycles; in_ready=0 until one cycle after out_ready rises.
- Reset pulse during the 4th BUSY cycle of a MUL -> out_valid=0 and result=0 immediately; in_ready=1 after release; the following ADD 0x03+0x04 gives 0x07.
- SEQ_ALU_MUL_EN undefined: MUL a=0x02, b=0x03 -> illegal=1, result=0, zero=1; out_valid one cycle after accept.
